// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register-read stage.
// RF_WB_BYPASS_EN (see rf_read_stage_mp) selects same-cycle write-back bypass on capture.
package rf_pkg;

  localparam int unsigned NumPregsDef = 64;
  localparam int unsigned PregWDef    = 6;
  localparam int unsigned DataWDef    = 32;
  localparam int unsigned NumWbDef    = 2;
  localparam int unsigned PayloadWDef = 137;

  // Payload field positions; the stage itself treats the payload as opaque.
  localparam int unsigned RobPtrLsb = 32;
  localparam int unsigned RobPtrMsb = 37;
  localparam int unsigned CtrlLsb   = 97;
  localparam int unsigned CtrlMsb   = 103;
  localparam int unsigned PcLsb     = 105;
  localparam int unsigned PcMsb     = 136;

  typedef struct packed {
    logic                en;
    logic [PregWDef-1:0] idx;
    logic [DataWDef-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/rf_wb_match.sv
// Priority match of one register index against all write-back ports.
// The highest-numbered enabled port with a matching index supplies the data.
module rf_wb_match #(
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic [PREG_W-1:0]        idx_i,
  input  logic [NUM_WB-1:0]        wb_en_i,
  input  logic [NUM_WB*PREG_W-1:0] wb_idx_i,
  input  logic [NUM_WB*DATA_W-1:0] wb_data_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_en_i[k] && (wb_idx_i[k*PREG_W +: PREG_W] == idx_i)) begin
        hit_o  = 1'b1;
        data_o = wb_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rf_read_stage_mp.sv
// Register-read stage: physical RF with NUM_WB write ports, two-operand read, valid/ready output
// register with FREEZE/FLUSH and held-operand refresh. Define RF_WB_BYPASS_EN for capture bypass.
module rf_read_stage_mp
  import rf_pkg::*;
#(
  parameter int unsigned NUM_PREGS = NumPregsDef,
  parameter int unsigned PREG_W    = PregWDef,
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned NUM_WB    = NumWbDef,
  parameter int unsigned PAYLOAD_W = PayloadWDef
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FREEZE,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [PAYLOAD_W-1:0]     IN_PAYLOAD,
  input  logic [PREG_W-1:0]        IN_SRC_A,
  input  logic [PREG_W-1:0]        IN_SRC_B,
  input  logic                     IN_USE_B,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [PAYLOAD_W-1:0]     OUT_PAYLOAD,
  output logic [DATA_W-1:0]        OUT_OPND_A,
  output logic [DATA_W-1:0]        OUT_OPND_B,
  input  logic [NUM_WB-1:0]        WB_EN,
  input  logic [NUM_WB*PREG_W-1:0] WB_IDX,
  input  logic [NUM_WB*DATA_W-1:0] WB_DATA,
  input  logic [PREG_W-1:0]        DBG_RD_IDX,
  output logic [DATA_W-1:0]        DBG_RD_DATA
);

`ifdef RF_WB_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [DATA_W-1:0]    rf_q [NUM_PREGS];
  logic [DATA_W-1:0]    rf_d [NUM_PREGS];
  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [DATA_W-1:0]    opnd_a_q, opnd_a_d;
  logic [DATA_W-1:0]    opnd_b_q, opnd_b_d;
  logic [PREG_W-1:0]    src_a_q, src_a_d;
  logic [PREG_W-1:0]    src_b_q, src_b_d;
  logic                 use_b_q, use_b_d;

  logic                 accept, leaving, held;
  logic                 cap_a_hit, cap_b_hit, ref_a_hit, ref_b_hit;
  logic [DATA_W-1:0]    cap_a_data, cap_b_data, ref_a_data, ref_b_data;
  logic [DATA_W-1:0]    cap_a_val, cap_b_val;

  assign IN_READY = !RESET && !FREEZE && !FLUSH && (!out_valid_q || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign leaving  = out_valid_q && OUT_READY && !FREEZE && !FLUSH;
  assign held     = out_valid_q && !leaving && !FLUSH;

  rf_wb_match #(.NUM_WB(NUM_WB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_cap_a (
    .idx_i(IN_SRC_A), .wb_en_i(WB_EN), .wb_idx_i(WB_IDX), .wb_data_i(WB_DATA),
    .hit_o(cap_a_hit), .data_o(cap_a_data)
  );
  rf_wb_match #(.NUM_WB(NUM_WB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_cap_b (
    .idx_i(IN_SRC_B), .wb_en_i(WB_EN), .wb_idx_i(WB_IDX), .wb_data_i(WB_DATA),
    .hit_o(cap_b_hit), .data_o(cap_b_data)
  );
  rf_wb_match #(.NUM_WB(NUM_WB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_ref_a (
    .idx_i(src_a_q), .wb_en_i(WB_EN), .wb_idx_i(WB_IDX), .wb_data_i(WB_DATA),
    .hit_o(ref_a_hit), .data_o(ref_a_data)
  );
  rf_wb_match #(.NUM_WB(NUM_WB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_ref_b (
    .idx_i(src_b_q), .wb_en_i(WB_EN), .wb_idx_i(WB_IDX), .wb_data_i(WB_DATA),
    .hit_o(ref_b_hit), .data_o(ref_b_data)
  );

  assign cap_a_val = (BypassEn && cap_a_hit) ? cap_a_data : rf_q[IN_SRC_A];
  assign cap_b_val = (BypassEn && cap_b_hit) ? cap_b_data : rf_q[IN_SRC_B];

  // Ascending port order makes the highest enabled port win on index collisions.
  always_comb begin
    rf_d = rf_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (WB_EN[k]) begin
        rf_d[WB_IDX[k*PREG_W +: PREG_W]] = WB_DATA[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (FLUSH) begin
      out_valid_d = 1'b0;
    end else if (FREEZE) begin
      out_valid_d = out_valid_q;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    payload_d = payload_q;
    opnd_a_d  = opnd_a_q;
    opnd_b_d  = opnd_b_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    use_b_d   = use_b_q;
    if (accept) begin
      payload_d = IN_PAYLOAD;
      src_a_d   = IN_SRC_A;
      src_b_d   = IN_SRC_B;
      use_b_d   = IN_USE_B;
      opnd_a_d  = cap_a_val;
      opnd_b_d  = IN_USE_B ? cap_b_val : '0;
    end else if (held) begin
      // A stalled instruction keeps picking up late write-backs to its sources.
      if (ref_a_hit) opnd_a_d = ref_a_data;
      if (use_b_q && ref_b_hit) opnd_b_d = ref_b_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_PREGS; i++) rf_q[i] <= '0;
      out_valid_q <= 1'b0;
      payload_q   <= '0;
      opnd_a_q    <= '0;
      opnd_b_q    <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      use_b_q     <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
      opnd_a_q    <= opnd_a_d;
      opnd_b_q    <= opnd_b_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      use_b_q     <= use_b_d;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign OUT_PAYLOAD = payload_q;
  assign OUT_OPND_A  = opnd_a_q;
  assign OUT_OPND_B  = opnd_b_q;
  assign DBG_RD_DATA = rf_q[DBG_RD_IDX];

endmodule

// File: tb/tb_rf_read_stage_mp.sv
// Directed bench for rf_read_stage_mp: handshake, write-back collision, bypass, refresh,
// FREEZE/FLUSH and asynchronous reset, checked with immediate assertions.
module tb_rf_read_stage_mp;
  import rf_pkg::*;

  localparam int unsigned PW = PayloadWDef;
  localparam int unsigned IW = PregWDef;
  localparam int unsigned DW = DataWDef;
  localparam int unsigned NW = NumWbDef;

`ifdef RF_WB_BYPASS_EN
  localparam logic [31:0] BypExp = 32'h55;
`else
  localparam logic [31:0] BypExp = 32'h0;
`endif

  logic CLK = 1'b0;
  logic RESET, FREEZE, FLUSH, IN_VALID, IN_READY, IN_USE_B, OUT_VALID, OUT_READY;
  logic [PW-1:0]    IN_PAYLOAD, OUT_PAYLOAD;
  logic [IW-1:0]    IN_SRC_A, IN_SRC_B, DBG_RD_IDX;
  logic [DW-1:0]    OUT_OPND_A, OUT_OPND_B, DBG_RD_DATA;
  logic [NW-1:0]    WB_EN;
  logic [NW*IW-1:0] WB_IDX;
  logic [NW*DW-1:0] WB_DATA;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] p1, p2, p3, p4, p5;

  always #5 CLK = ~CLK;

  rf_read_stage_mp dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PAYLOAD(IN_PAYLOAD),
    .IN_SRC_A(IN_SRC_A), .IN_SRC_B(IN_SRC_B), .IN_USE_B(IN_USE_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PAYLOAD(OUT_PAYLOAD),
    .OUT_OPND_A(OUT_OPND_A), .OUT_OPND_B(OUT_OPND_B),
    .WB_EN(WB_EN), .WB_IDX(WB_IDX), .WB_DATA(WB_DATA),
    .DBG_RD_IDX(DBG_RD_IDX), .DBG_RD_DATA(DBG_RD_DATA)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb(input int port, input logic [IW-1:0] idx, input logic [DW-1:0] data);
    WB_EN[port]            = 1'b1;
    WB_IDX[port*IW +: IW]  = idx;
    WB_DATA[port*DW +: DW] = data;
  endtask

  task automatic wb_off();
    WB_EN   = '0;
    WB_IDX  = '0;
    WB_DATA = '0;
  endtask

  task automatic issue(input logic [PW-1:0] pl, input logic [IW-1:0] a, input logic [IW-1:0] b,
                       input logic ub);
    IN_VALID   = 1'b1;
    IN_PAYLOAD = pl;
    IN_SRC_A   = a;
    IN_SRC_B   = b;
    IN_USE_B   = ub;
  endtask

  function automatic logic [PW-1:0] mk(input logic [5:0] rob, input logic [31:0] pc,
                                       input logic [6:0] ctrl);
    logic [PW-1:0] p;
    p = '0;
    p[RobPtrMsb:RobPtrLsb] = rob;
    p[PcMsb:PcLsb]         = pc;
    p[CtrlMsb:CtrlLsb]     = ctrl;
    p[15:0]                = {rob, 10'h155};
    return p;
  endfunction

  initial begin
    p1 = mk(6'h01, 32'h0000_1000, 7'h11);
    p2 = mk(6'h02, 32'h0000_2004, 7'h22);
    p3 = mk(6'h03, 32'h0000_3008, 7'h33);
    p4 = mk(6'h04, 32'hDEAD_BEEF, 7'h44);
    p5 = mk(6'h05, 32'h0000_5010, 7'h55);
    RESET = 1'b1; FREEZE = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
    IN_VALID = 1'b0; IN_PAYLOAD = '0; IN_SRC_A = '0; IN_SRC_B = '0; IN_USE_B = 1'b0;
    DBG_RD_IDX = 6'd5;
    wb_off();
    #12;
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_in_ready", IN_READY, 1'b0);
    chk("rst_payload", OUT_PAYLOAD, '0);
    chk("rst_dbg", DBG_RD_DATA, '0);
    RESET = 1'b0;

    // Basic write then read
    wb(0, 6'd5, 32'h1234);
    tick();
    wb_off();
    chk("wr_p5", DBG_RD_DATA, 32'h1234);
    issue(p1, 6'd5, 6'd0, 1'b1);
    #1 chk("rdy_empty", IN_READY, 1'b1);
    tick();
    IN_VALID = 1'b0;
    chk("basic_valid", OUT_VALID, 1'b1);
    chk("basic_a", OUT_OPND_A, 32'h1234);
    chk("basic_b", OUT_OPND_B, 32'h0);
    chk("basic_payload", OUT_PAYLOAD, p1);
    chk("rdy_stalled", IN_READY, 1'b0);

    // Write-port collision: port 1 wins
    wb(0, 6'd7, 32'hAAAA);
    wb(1, 6'd7, 32'hBBBB);
    DBG_RD_IDX = 6'd7;
    tick();
    wb_off();
    chk("collide_p7", DBG_RD_DATA, 32'hBBBB);
    chk("hold_a", OUT_OPND_A, 32'h1234);

    // Drain, then hold an instruction reading p7/p12
    OUT_READY = 1'b1;
    tick();
    chk("drain_valid", OUT_VALID, 1'b0);
    OUT_READY = 1'b0;
    issue(p2, 6'd7, 6'd12, 1'b1);
    tick();
    IN_VALID = 1'b0;
    chk("cap_a_p7", OUT_OPND_A, 32'hBBBB);
    chk("cap_b_p12", OUT_OPND_B, 32'h0);
    wb(0, 6'd7, 32'h1111);
    wb(1, 6'd12, 32'h77);
    tick();
    wb_off();
    chk("refresh_a", OUT_OPND_A, 32'h1111);
    chk("refresh_b", OUT_OPND_B, 32'h77);
    wb(0, 6'd12, 32'h1);
    wb(1, 6'd12, 32'h2);
    tick();
    wb_off();
    chk("refresh_collide_b", OUT_OPND_B, 32'h2);

    // Leave and accept in the same cycle; USE_B=0 blocks B refresh
    OUT_READY = 1'b1;
    issue(p3, 6'd5, 6'd12, 1'b0);
    #1 chk("rdy_pass", IN_READY, 1'b1);
    tick();
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    chk("pass_valid", OUT_VALID, 1'b1);
    chk("pass_payload", OUT_PAYLOAD, p3);
    chk("nouse_b_cap", OUT_OPND_B, 32'h0);
    wb(0, 6'd12, 32'h99);
    DBG_RD_IDX = 6'd12;
    tick();
    wb_off();
    chk("nouse_b_hold", OUT_OPND_B, 32'h0);
    chk("nouse_p12", DBG_RD_DATA, 32'h99);

    // FREEZE holds the stage while the array still takes writes
    FREEZE = 1'b1;
    OUT_READY = 1'b1;
    issue(p4, 6'd7, 6'd7, 1'b1);
    wb(0, 6'd20, 32'hCAFE);
    DBG_RD_IDX = 6'd20;
    #1 chk("frz_in_ready", IN_READY, 1'b0);
    tick();
    wb_off();
    chk("frz_valid", OUT_VALID, 1'b1);
    chk("frz_payload", OUT_PAYLOAD, p3);
    chk("frz_a", OUT_OPND_A, 32'h1234);
    chk("frz_wb_p20", DBG_RD_DATA, 32'hCAFE);

    // FLUSH beats FREEZE
    FLUSH = 1'b1;
    #1 chk("flush_in_ready", IN_READY, 1'b0);
    tick();
    chk("flush_valid", OUT_VALID, 1'b0);
    FREEZE = 1'b0;
    IN_VALID = 1'b0;
    tick();
    chk("flush_empty_valid", OUT_VALID, 1'b0);
    FLUSH = 1'b0;
    OUT_READY = 1'b0;

    // Same-cycle write and capture of p9
    issue(p5, 6'd9, 6'd9, 1'b1);
    wb(0, 6'd9, 32'h55);
    DBG_RD_IDX = 6'd9;
    tick();
    IN_VALID = 1'b0;
    wb_off();
    chk("byp_valid", OUT_VALID, 1'b1);
    chk("byp_a", OUT_OPND_A, BypExp);
    chk("byp_b", OUT_OPND_B, BypExp);
    chk("byp_p9", DBG_RD_DATA, 32'h55);

    // Asynchronous reset between edges
    #2 RESET = 1'b1;
    #1;
    chk("arst_valid", OUT_VALID, 1'b0);
    chk("arst_dbg_p9", DBG_RD_DATA, 32'h0);
    chk("arst_a", OUT_OPND_A, 32'h0);
    chk("arst_payload", OUT_PAYLOAD, '0);
    wb(0, 6'd9, 32'hF00D);
    tick();
    wb_off();
    chk("arst_no_wb", DBG_RD_DATA, 32'h0);
    #2 RESET = 1'b0;
    tick();
    chk("post_rst_ready", IN_READY, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
